// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry controller.
// Holds the key code constants, the entry FSM state type, the BCD/binary
// widths and the combinational BCD-to-binary helper.
package keypad_pkg;

  localparam int unsigned CodeW     = 4;
  localparam int unsigned BcdDigits = 4;
  localparam int unsigned BcdW      = 4 * BcdDigits;
  localparam int unsigned BinW      = 14;
  localparam int unsigned CountW    = 3;

  localparam logic [CodeW-1:0] KEY_BKSP = 4'hD;
  localparam logic [CodeW-1:0] KEY_CLR  = 4'hE;
  localparam logic [CodeW-1:0] KEY_ENT  = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StEntry,
    StHold
  } state_e;

  function automatic logic is_digit(input logic [CodeW-1:0] code);
    return code <= 4'd9;
  endfunction

  // Horner evaluation from the most significant digit; max 9999 fits BinW.
  function automatic logic [BinW-1:0] bcd_to_bin(input logic [BcdW-1:0] bcd);
    logic [BinW-1:0] acc;
    acc = '0;
    for (int i = BcdDigits - 1; i >= 0; i--) begin
      acc = acc * BinW'(10) + {{(BinW - 4){1'b0}}, bcd[i*4 +: 4]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Bundle between the key scanner / number consumer and the entry controller.
//   key_valid, key_code : scanner level and held key code
//   out_ready           : consumer accepts the entered number
//   out_valid, out_bcd, out_bin : entered number and its qualifier
//   entry_bcd, digit_count      : live entry buffer for display
//   err                 : one-cycle pulse on a rejected key
// The controller uses the slave modport; the environment uses master.
interface keypad_entry_ctrl_if;
  import keypad_pkg::*;

  logic                 key_valid;
  logic [CodeW-1:0]     key_code;
  logic                 out_ready;
  logic                 out_valid;
  logic [BcdW-1:0]      out_bcd;
  logic [BinW-1:0]      out_bin;
  logic [BcdW-1:0]      entry_bcd;
  logic [CountW-1:0]    digit_count;
  logic                 err;

  modport master (
    output key_valid,
    output key_code,
    output out_ready,
    input  out_valid,
    input  out_bcd,
    input  out_bin,
    input  entry_bcd,
    input  digit_count,
    input  err
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  out_ready,
    output out_valid,
    output out_bcd,
    output out_bin,
    output entry_bcd,
    output digit_count,
    output err
  );

endinterface

// File: rtl/keypad_debounce.sv
// Debounces the scanner level {key_valid, key_code} and produces a single
// key event per new press.
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_valid_i  : scanner reports a held key
//   key_code_i   : code of the held key
//   event_o      : one-cycle pulse when the stable state becomes a new held key
//   code_o       : code of the stable key (valid alongside event_o)
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid_i,
  input  logic [CodeW-1:0] key_code_i,
  output logic             event_o,
  output logic [CodeW-1:0] code_o
);

  localparam logic [7:0] CntMax = 8'(DEB_CYCLES - 1);

  logic [CodeW:0] sample_q, sample_d;
  logic [CodeW:0] stable_q, stable_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           event_q, event_d;
  logic [CodeW:0] in_sample;
  logic           saturated;

  assign in_sample = {key_valid_i, key_code_i};
  assign saturated = (cnt_q == CntMax);

  always_comb begin
    sample_d = sample_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    event_d  = 1'b0;

    // Any change restarts the run of identical samples.
    if (in_sample != sample_q) begin
      sample_d = in_sample;
      cnt_d    = '0;
    end else if (!saturated) begin
      cnt_d = cnt_q + 8'd1;
    end

    if (saturated) begin
      stable_d = sample_q;
      // New held key: from released or from a different code.
      event_d  = sample_q[CodeW] && (sample_q != stable_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      event_q  <= 1'b0;
    end else begin
      sample_q <= sample_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      event_q  <= event_d;
    end
  end

  assign event_o = event_q;
  assign code_o  = stable_q[CodeW-1:0];

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad number entry controller.
// Debounced key events build a decimal number of up to MAX_DIGITS digits
// (backspace, clear, enter supported). On enter the number is presented as
// BCD and binary with a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of keypad_entry_ctrl_if (key inputs, output
//                number with handshake, live entry display, err pulse)
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  keypad_entry_ctrl_if.slave  bus
);

  localparam logic [CountW-1:0] MaxCount = CountW'(MAX_DIGITS);

  logic             key_ev;
  logic [CodeW-1:0] key_code;

  state_e            state_q, state_d;
  logic [BcdW-1:0]   entry_q, entry_d;
  logic [CountW-1:0] count_q, count_d;
  logic [BcdW-1:0]   out_bcd_q, out_bcd_d;
  logic [BinW-1:0]   out_bin_q, out_bin_d;
  logic              err_q, err_d;

  keypad_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid_i (bus.key_valid),
    .key_code_i  (bus.key_code),
    .event_o     (key_ev),
    .code_o      (key_code)
  );

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    count_d   = count_q;
    out_bcd_d = out_bcd_q;
    out_bin_d = out_bin_q;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (key_ev) begin
          if (is_digit(key_code)) begin
            entry_d = {{(BcdW - CodeW){1'b0}}, key_code};
            count_d = CountW'(1);
            state_d = StEntry;
          end else if (key_code == KEY_BKSP || key_code == KEY_ENT) begin
            err_d = 1'b1;
          end else if (key_code == KEY_CLR) begin
            entry_d = '0;
            count_d = '0;
          end
        end
      end

      StEntry: begin
        if (key_ev) begin
          if (is_digit(key_code)) begin
            if (count_q < MaxCount) begin
              entry_d = {entry_q[BcdW-CodeW-1:0], key_code};
              count_d = count_q + CountW'(1);
            end else begin
              err_d = 1'b1;
            end
          end else begin
            case (key_code)
              KEY_BKSP: begin
                entry_d = {{CodeW{1'b0}}, entry_q[BcdW-1:CodeW]};
                count_d = count_q - CountW'(1);
                if (count_q == CountW'(1)) state_d = StIdle;
              end
              KEY_CLR: begin
                entry_d = '0;
                count_d = '0;
                state_d = StIdle;
              end
              KEY_ENT: begin
                out_bcd_d = entry_q;
                out_bin_d = bcd_to_bin(entry_q);
                state_d   = StHold;
              end
              default: ;  // spare codes A-C ignored
            endcase
          end
        end
      end

      StHold: begin
        // Every key is rejected here, including one in the handshake cycle.
        if (key_ev) err_d = 1'b1;
        if (bus.out_ready) begin
          state_d = StIdle;
          entry_d = '0;
          count_d = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      entry_q   <= '0;
      count_q   <= '0;
      out_bcd_q <= '0;
      out_bin_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      count_q   <= count_d;
      out_bcd_q <= out_bcd_d;
      out_bin_q <= out_bin_d;
      err_q     <= err_d;
    end
  end

  assign bus.out_valid   = (state_q == StHold);
  assign bus.out_bcd     = out_bcd_q;
  assign bus.out_bin     = out_bin_q;
  assign bus.entry_bcd   = entry_q;
  assign bus.digit_count = count_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl against a digit-list model.
module tb_keypad_entry_ctrl;

  localparam int DEB   = 16;
  localparam int MAXD  = 4;
  localparam int PRESS = DEB + 6;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // Reference model: list of entered digits, most recent last.
  int m_digits[$];
  bit m_hold;
  int m_out_bcd;
  int m_out_bin;

  keypad_entry_ctrl_if ifc ();

  keypad_entry_ctrl #(
    .DEB_CYCLES (DEB),
    .MAX_DIGITS (MAXD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_bcd();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  function automatic int model_bin();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  function automatic void model_reset();
    m_digits.delete();
    m_hold    = 0;
    m_out_bcd = 0;
    m_out_bin = 0;
  endfunction

  // Applies one key event to the model; returns the expected err pulse count.
  function automatic int model_key(input int code);
    if (m_hold) return 1;
    if (code <= 9) begin
      if (m_digits.size() == MAXD) return 1;
      m_digits.push_back(code);
      return 0;
    end
    case (code)
      13: begin
        if (m_digits.size() == 0) return 1;
        void'(m_digits.pop_back());
        return 0;
      end
      14: begin
        m_digits.delete();
        return 0;
      end
      15: begin
        if (m_digits.size() == 0) return 1;
        m_hold    = 1;
        m_out_bcd = model_bcd();
        m_out_bin = model_bin();
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  // Hold a key well past the debounce window, then release it; counts err.
  task automatic press(input int code, output int nerr);
    nerr = 0;
    ifc.key_code  = 4'(code);
    ifc.key_valid = 1'b1;
    repeat (PRESS) begin
      @(posedge clk); #1;
      if (ifc.err) nerr++;
    end
    ifc.key_valid = 1'b0;
    repeat (PRESS) begin
      @(posedge clk); #1;
      if (ifc.err) nerr++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    if (m_hold) begin
      m_hold = 0;
      m_digits.delete();
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    ifc.key_valid = 1'b0;
    ifc.key_code  = 4'h0;
    ifc.out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ifc.out_valid, ifc.err, ifc.out_bcd, ifc.out_bin, ifc.entry_bcd, ifc.digit_count}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b e=%b bcd=%h bin=%0d ent=%h cnt=%0d want all 0",
               ifc.out_valid, ifc.err, ifc.out_bcd, ifc.out_bin, ifc.entry_bcd,
               ifc.digit_count);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_entry();
    int nerr;
    int tot = 0;
    int unstable = 0;
    int codes[4] = '{1, 2, 3, 15};
    foreach (codes[i]) begin
      press(codes[i], nerr);
      tot += nerr;
      void'(model_key(codes[i]));
    end
    n_checks++;
    if (tot !== 0) begin
      n_fail++;
      $display("FAIL basic_err: got %0d err pulses want 0", tot);
    end
    n_checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_bcd !== 16'h0123 || ifc.out_bin !== 14'd123) begin
      n_fail++;
      $display("FAIL basic_out: got v=%b bcd=%h bin=%0d want v=1 bcd=0123 bin=123",
               ifc.out_valid, ifc.out_bcd, ifc.out_bin);
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (ifc.out_valid !== 1'b1 || ifc.out_bcd !== 16'h0123 || ifc.out_bin !== 14'd123)
        unstable++;
    end
    n_checks++;
    if (unstable !== 0) begin
      n_fail++;
      $display("FAIL basic_hold: got %0d unstable cycles want 0", unstable);
    end
    handshake();
    n_checks++;
    if (ifc.out_valid !== 1'b0 || ifc.digit_count !== 3'd0 || ifc.entry_bcd !== 16'h0) begin
      n_fail++;
      $display("FAIL basic_accept: got v=%b cnt=%0d ent=%h want v=0 cnt=0 ent=0000",
               ifc.out_valid, ifc.digit_count, ifc.entry_bcd);
    end
  endtask

  task automatic test_overflow();
    int nerr;
    int errs[5];
    int codes[5] = '{5, 6, 7, 8, 9};
    foreach (codes[i]) begin
      press(codes[i], nerr);
      errs[i] = nerr;
      void'(model_key(codes[i]));
    end
    n_checks++;
    if (errs[4] !== 1 || errs[3] !== 0) begin
      n_fail++;
      $display("FAIL overflow_err: got %0d/%0d pulses on keys 8/9 want 0/1", errs[3], errs[4]);
    end
    n_checks++;
    if (ifc.entry_bcd !== 16'h5678 || ifc.digit_count !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_buf: got %h/%0d want 5678/4", ifc.entry_bcd, ifc.digit_count);
    end
    press(13, nerr);
    void'(model_key(13));
    n_checks++;
    if (ifc.entry_bcd !== 16'h0567 || ifc.digit_count !== 3'd3 || nerr !== 0) begin
      n_fail++;
      $display("FAIL overflow_bksp: got %h/%0d err=%0d want 0567/3 err=0",
               ifc.entry_bcd, ifc.digit_count, nerr);
    end
    press(14, nerr);
    void'(model_key(14));
  endtask

  task automatic test_glitch();
    int nerr;
    int bad = 0;
    ifc.key_code = 4'h7;
    for (int i = 0; i < 120; i++) begin
      ifc.key_valid = ((i / 3) % 2 == 0);
      @(posedge clk); #1;
      if (ifc.err || ifc.digit_count !== 3'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL glitch_quiet: got %0d cycles with activity want 0", bad);
    end
    ifc.key_valid = 1'b1;
    repeat (200) @(posedge clk);
    ifc.key_valid = 1'b0;
    repeat (PRESS) @(posedge clk);
    #1;
    void'(model_key(7));
    n_checks++;
    if (ifc.digit_count !== 3'd1 || ifc.entry_bcd !== 16'h0007) begin
      n_fail++;
      $display("FAIL glitch_hold: got %0d/%h want 1/0007", ifc.digit_count, ifc.entry_bcd);
    end
    press(14, nerr);
    void'(model_key(14));
  endtask

  task automatic test_errors();
    int nerr;
    press(15, nerr);
    void'(model_key(15));
    n_checks++;
    if (nerr !== 1 || ifc.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_enter: got err=%0d v=%b want err=1 v=0", nerr, ifc.out_valid);
    end
    press(2, nerr);
    void'(model_key(2));
    press(15, nerr);
    void'(model_key(15));
    press(4, nerr);
    void'(model_key(4));
    n_checks++;
    if (nerr !== 1 || ifc.out_valid !== 1'b1 || ifc.out_bcd !== 16'h0002) begin
      n_fail++;
      $display("FAIL hold_digit: got err=%0d v=%b bcd=%h want err=1 v=1 bcd=0002",
               nerr, ifc.out_valid, ifc.out_bcd);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int nerr;
    int early = 0;
    press(1, nerr);
    void'(model_key(1));
    press(2, nerr);
    void'(model_key(2));
    n_checks++;
    if (ifc.digit_count !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_count: got %0d want 2", ifc.digit_count);
    end
    ifc.key_code  = 4'h3;
    ifc.key_valid = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({ifc.out_valid, ifc.err, ifc.out_bcd, ifc.out_bin, ifc.entry_bcd, ifc.digit_count}
        !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b ent=%h cnt=%0d bcd=%h want all 0",
               ifc.out_valid, ifc.entry_bcd, ifc.digit_count, ifc.out_bcd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (DEB) begin
      @(posedge clk); #1;
      if (ifc.digit_count !== 3'd0 || ifc.err) early++;
    end
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL mid_early_event: got %0d active cycles want 0", early);
    end
    repeat (10) @(posedge clk);
    ifc.key_valid = 1'b0;
    repeat (PRESS) @(posedge clk);
    #1;
    void'(model_key(3));
    n_checks++;
    if (ifc.digit_count !== 3'd1 || ifc.entry_bcd !== 16'h0003) begin
      n_fail++;
      $display("FAIL mid_late_event: got %0d/%h want 1/0003", ifc.digit_count, ifc.entry_bcd);
    end
    press(14, nerr);
    void'(model_key(14));
  endtask

  task automatic test_max();
    int nerr;
    int tot = 0;
    int codes[5] = '{9, 9, 9, 9, 15};
    foreach (codes[i]) begin
      press(codes[i], nerr);
      tot += nerr;
      void'(model_key(codes[i]));
    end
    n_checks++;
    if (tot !== 0 || ifc.out_bin !== 14'd9999 || ifc.out_bcd !== 16'h9999) begin
      n_fail++;
      $display("FAIL max_value: got err=%0d bcd=%h bin=%0d want 0/9999/9999",
               tot, ifc.out_bcd, ifc.out_bin);
    end
    handshake();
    press(5, nerr);
    void'(model_key(5));
    press(14, nerr);
    void'(model_key(14));
    press(15, nerr);
    void'(model_key(15));
    n_checks++;
    if (nerr !== 1 || ifc.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_enter: got err=%0d v=%b want err=1 v=0", nerr, ifc.out_valid);
    end
  endtask

  task automatic test_random();
    int nerr;
    int exp_err;
    int code;
    for (int i = 0; i < 60; i++) begin
      if (m_hold && $urandom_range(0, 2) == 0) begin
        handshake();
        exp_err = 0;
        nerr    = 0;
      end else begin
        code = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 9))
                                          : int'($urandom_range(10, 15));
        press(code, nerr);
        exp_err = model_key(code);
      end
      n_checks++;
      if (nerr !== exp_err || ifc.entry_bcd !== 16'(model_bcd())
          || ifc.digit_count !== 3'(m_digits.size()) || ifc.out_valid !== m_hold
          || ifc.out_bcd !== 16'(m_out_bcd) || ifc.out_bin !== 14'(m_out_bin)) begin
        n_fail++;
        $display("FAIL random_%0d: got err=%0d ent=%h cnt=%0d v=%b bcd=%h bin=%0d want err=%0d ent=%h cnt=%0d v=%b bcd=%h bin=%0d",
                 i, nerr, ifc.entry_bcd, ifc.digit_count, ifc.out_valid, ifc.out_bcd,
                 ifc.out_bin, exp_err, model_bcd(), m_digits.size(), m_hold, m_out_bcd,
                 m_out_bin);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_entry();
    test_overflow();
    test_glitch();
    test_errors();
    test_reset_mid();
    test_max();
    handshake();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
